// File: rtl/timebase_pkg.sv
// rtl/timebase_pkg.sv - shared mode encodings and prescale helper for the timebase scheduler
package timebase_pkg;

    // Seconds-channel operating modes; the mode output carries these codes directly.
    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_PAUSE = 2'b01;
    localparam logic [1:0] MODE_FAST  = 2'b10;

    // System clocks per base tick.
    function automatic int calc_pre(input int clk_hz, input int base_hz);
        return clk_hz / base_hz;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - enabled modulo counter with synchronous clear and registered wrap pulse
module mod_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         wrap
);

    logic [W-1:0] cnt;

    // Count 0..limit on each enable; wrap is high for the cycle after the count returns to 0.
    // Clear dominates enable, so a clear on a would-be wrap edge also suppresses the pulse.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (en) begin
            if (cnt >= limit) begin
                cnt  <= '0;
                wrap <= 1'b1;
            end else begin
                cnt  <= cnt + W'(1);
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/timebase_scheduler.sv
// rtl/timebase_scheduler.sv - shared prescaler deriving base, sample and seconds enable strobes
module timebase_scheduler
    import timebase_pkg::*;
#(
    parameter int CLK_HZ         = 100000000,
    parameter int BASE_HZ        = 1000,
    parameter int SEC_DIV        = 1000,
    parameter int FAST_DIV       = 125,
    parameter int SAMPLE_DIV_RST = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_en,
    input  logic       fast_en,
    input  logic       sync_sec,
    input  logic       cfg_valid,
    input  logic [7:0] cfg_div,
    output logic       cfg_ready,
    output logic       cfg_err,
    output logic       tick_base,
    output logic       tick_sample,
    output logic       tick_sec,
    output logic [1:0] mode
);

    localparam int PRE     = calc_pre(CLK_HZ, BASE_HZ);
    localparam int PRE_W   = cnt_width(PRE);
    localparam int SEC_MAX = (SEC_DIV > FAST_DIV) ? SEC_DIV : FAST_DIV;
    localparam int SEC_W   = cnt_width(SEC_MAX);

    localparam logic [PRE_W-1:0] PRE_LIM  = PRE_W'(PRE - 1);
    localparam logic [SEC_W-1:0] SEC_LIM  = SEC_W'(SEC_DIV - 1);
    localparam logic [SEC_W-1:0] FAST_LIM = SEC_W'(FAST_DIV - 1);
    localparam logic [7:0]       SAMP_RST = 8'(SAMPLE_DIV_RST);

    // pre_wrap is one cycle ahead of tick_base: every channel steps on the edge that
    // raises tick_base, so their registered wrap pulses line up with it.
    logic             pre_wrap;
    logic [1:0]       state;
    logic [1:0]       next_state;
    logic             fast_change;
    logic             sec_en;
    logic             sec_clr;
    logic [SEC_W-1:0] sec_limit;
    logic [7:0]       samp_div;
    logic [7:0]       pend_div;
    logic             pend_valid;
    logic             cfg_accept;
    logic             cfg_apply;
    logic             samp_clr;

    // Free-running prescaler, active in every mode.
    mod_counter #(.W(PRE_W)) u_pre (
        .clk   (clk),
        .clr   (rst),
        .en    (1'b1),
        .limit (PRE_LIM),
        .wrap  (pre_wrap)
    );

    // Base strobe is the prescaler wrap delayed by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_base <= 1'b0;
        end else begin
            tick_base <= pre_wrap;
        end
    end

    // Mode request decode: fast-set overrides run/pause.
    always_comb begin
        next_state = MODE_RUN;
        if (fast_en) begin
            next_state = MODE_FAST;
        end else if (!run_en) begin
            next_state = MODE_PAUSE;
        end
    end

    // Mode register follows the request every clock; reset parks it in PAUSE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MODE_PAUSE;
        end else begin
            state <= next_state;
        end
    end

    assign mode = state;

    // Entering or leaving FAST restarts the seconds phase; PAUSE<->RUN keeps it.
    assign fast_change = (next_state == MODE_FAST) != (state == MODE_FAST);
    assign sec_en      = pre_wrap && (state != MODE_PAUSE);
    assign sec_clr     = rst || sync_sec || fast_change;
    assign sec_limit   = (state == MODE_FAST) ? FAST_LIM : SEC_LIM;

    // Seconds channel; a clear on the wrapping edge swallows that tick_sec.
    mod_counter #(.W(SEC_W)) u_sec (
        .clk   (clk),
        .clr   (sec_clr),
        .en    (sec_en),
        .limit (sec_limit),
        .wrap  (tick_sec)
    );

    // A pending divider is applied on the edge that raises tick_base.
    assign cfg_accept = cfg_valid && cfg_ready;
    assign cfg_apply  = pre_wrap && pend_valid;

    // Config handshake: zero is rejected with an error pulse; a nonzero value is held
    // pending until the next base tick, and ready returns one cycle after it lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_div   <= SAMP_RST;
            pend_div   <= 8'd0;
            pend_valid <= 1'b0;
            cfg_ready  <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= cfg_accept && (cfg_div == 8'd0);
            if (cfg_apply) begin
                samp_div   <= pend_div;
                pend_valid <= 1'b0;
            end
            if (cfg_accept && (cfg_div != 8'd0)) begin
                pend_div   <= cfg_div;
                pend_valid <= 1'b1;
                cfg_ready  <= 1'b0;
            end else begin
                cfg_ready  <= !pend_valid;
            end
        end
    end

    // Restarting the sample phase on a divider change also suppresses that tick.
    assign samp_clr = rst || cfg_apply;

    // Sample channel, counting base ticks modulo samp_div.
    mod_counter #(.W(8)) u_samp (
        .clk   (clk),
        .clr   (samp_clr),
        .en    (pre_wrap),
        .limit (samp_div - 8'd1),
        .wrap  (tick_sample)
    );

endmodule

// File: tb/tb_timebase_scheduler.sv
// tb/tb_timebase_scheduler.sv - directed self-checking bench for timebase_scheduler
module tb_timebase_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_en;
    logic       fast_en;
    logic       sync_sec;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       tick_base;
    logic       tick_sample;
    logic       tick_sec;
    logic [1:0] mode;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    localparam logic [1:0] M_RUN   = 2'b00;
    localparam logic [1:0] M_PAUSE = 2'b01;
    localparam logic [1:0] M_FAST  = 2'b10;

    always #5 clk = ~clk;

    timebase_scheduler #(
        .CLK_HZ         (40),
        .BASE_HZ        (10),
        .SEC_DIV        (5),
        .FAST_DIV       (2),
        .SAMPLE_DIV_RST (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run_en      (run_en),
        .fast_en     (fast_en),
        .sync_sec    (sync_sec),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
        .cfg_ready   (cfg_ready),
        .cfg_err     (cfg_err),
        .tick_base   (tick_base),
        .tick_sample (tick_sample),
        .tick_sec    (tick_sec),
        .mode        (mode)
    );

    function automatic logic base_exp(input int c);
        return (c > 0) && (c % 4 == 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        run_en    = 1'b1;
        fast_en   = 1'b0;
        sync_sec  = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;
    endtask

    task automatic release_reset(input int n);
        idle_inputs();
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
        step();
        cyc = 0;
    endtask

    task automatic advance_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        vectors++; if (tick_base !== 1'b0) begin miscompares++; $display("FAIL rst.tick_base got %b want 0", tick_base); end
        vectors++; if (tick_sample !== 1'b0) begin miscompares++; $display("FAIL rst.tick_sample got %b want 0", tick_sample); end
        vectors++; if (tick_sec !== 1'b0) begin miscompares++; $display("FAIL rst.tick_sec got %b want 0", tick_sec); end
        vectors++; if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL rst.cfg_ready got %b want 0", cfg_ready); end
        vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL rst.cfg_err got %b want 0", cfg_err); end
        vectors++; if (mode !== M_PAUSE) begin miscompares++; $display("FAIL rst.mode got %b want 01", mode); end
        rst = 1'b0;
        step();
        cyc = 0;
        vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL rel.cfg_ready got %b want 1", cfg_ready); end
        vectors++; if (mode !== M_RUN) begin miscompares++; $display("FAIL rel.mode got %b want 00", mode); end
        vectors++; if (tick_base !== 1'b0) begin miscompares++; $display("FAIL rel.tick_base got %b want 0", tick_base); end
    endtask

    task automatic test_run();
        logic es;
        logic et;
        release_reset(2);
        for (int i = 0; i < 42; i++) begin
            es = (cyc == 12) || (cyc == 24) || (cyc == 36);
            et = (cyc == 20) || (cyc == 40);
            vectors++; if (tick_base !== base_exp(cyc)) begin miscompares++; $display("FAIL run.tick_base cyc=%0d got %b want %b", cyc, tick_base, base_exp(cyc)); end
            vectors++; if (tick_sample !== es) begin miscompares++; $display("FAIL run.tick_sample cyc=%0d got %b want %b", cyc, tick_sample, es); end
            vectors++; if (tick_sec !== et) begin miscompares++; $display("FAIL run.tick_sec cyc=%0d got %b want %b", cyc, tick_sec, et); end
            vectors++; if (mode !== M_RUN) begin miscompares++; $display("FAIL run.mode cyc=%0d got %b want 00", cyc, mode); end
            step();
        end
    endtask

    task automatic test_cfg();
        logic er;
        logic es;
        release_reset(2);
        advance_to(5);
        vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL cfg.ready_pre got %b want 1", cfg_ready); end
        cfg_valid = 1'b1;
        cfg_div   = 8'd2;
        step();
        cfg_valid = 1'b0;
        while (cyc < 33) begin
            er = !((cyc >= 6) && (cyc <= 8));
            es = (cyc == 16) || (cyc == 24) || (cyc == 32);
            vectors++; if (cfg_ready !== er) begin miscompares++; $display("FAIL cfg.ready cyc=%0d got %b want %b", cyc, cfg_ready, er); end
            vectors++; if (tick_sample !== es) begin miscompares++; $display("FAIL cfg.tick_sample cyc=%0d got %b want %b", cyc, tick_sample, es); end
            vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL cfg.err cyc=%0d got %b want 0", cyc, cfg_err); end
            step();
        end
        cfg_valid = 1'b1;
        cfg_div   = 8'd0;
        step();
        cfg_valid = 1'b0;
        vectors++; if (cfg_err !== 1'b1) begin miscompares++; $display("FAIL cfg.zero_err got %b want 1", cfg_err); end
        vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL cfg.zero_ready got %b want 1", cfg_ready); end
        step();
        vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL cfg.err_pulse got %b want 0", cfg_err); end
        while (cyc < 50) begin
            es = (cyc == 40) || (cyc == 48);
            vectors++; if (tick_sample !== es) begin miscompares++; $display("FAIL cfg.zero_sample cyc=%0d got %b want %b", cyc, tick_sample, es); end
            step();
        end
    endtask

    task automatic test_pause();
        logic et;
        release_reset(2);
        advance_to(9);
        run_en = 1'b0;
        step();
        while (cyc < 30) begin
            vectors++; if (mode !== M_PAUSE) begin miscompares++; $display("FAIL pause.mode cyc=%0d got %b want 01", cyc, mode); end
            vectors++; if (tick_sec !== 1'b0) begin miscompares++; $display("FAIL pause.tick_sec cyc=%0d got %b want 0", cyc, tick_sec); end
            vectors++; if (tick_base !== base_exp(cyc)) begin miscompares++; $display("FAIL pause.tick_base cyc=%0d got %b want %b", cyc, tick_base, base_exp(cyc)); end
            step();
        end
        run_en = 1'b1;
        step();
        while (cyc < 42) begin
            et = (cyc == 40);
            vectors++; if (mode !== M_RUN) begin miscompares++; $display("FAIL resume.mode cyc=%0d got %b want 00", cyc, mode); end
            vectors++; if (tick_sec !== et) begin miscompares++; $display("FAIL resume.tick_sec cyc=%0d got %b want %b", cyc, tick_sec, et); end
            step();
        end
    endtask

    task automatic test_fast();
        logic et;
        release_reset(2);
        advance_to(9);
        fast_en = 1'b1;
        run_en  = 1'b0;
        step();
        while (cyc <= 32) begin
            et = (cyc == 16) || (cyc == 24) || (cyc == 32);
            vectors++; if (mode !== M_FAST) begin miscompares++; $display("FAIL fast.mode cyc=%0d got %b want 10", cyc, mode); end
            vectors++; if (tick_sec !== et) begin miscompares++; $display("FAIL fast.tick_sec cyc=%0d got %b want %b", cyc, tick_sec, et); end
            if (cyc == 32) begin
                fast_en = 1'b0;
                run_en  = 1'b1;
            end
            step();
        end
        while (cyc < 54) begin
            et = (cyc == 52);
            vectors++; if (mode !== M_RUN) begin miscompares++; $display("FAIL unfast.mode cyc=%0d got %b want 00", cyc, mode); end
            vectors++; if (tick_sec !== et) begin miscompares++; $display("FAIL unfast.tick_sec cyc=%0d got %b want %b", cyc, tick_sec, et); end
            step();
        end
    endtask

    task automatic test_sync();
        logic et;
        release_reset(2);
        advance_to(19);
        sync_sec = 1'b1;
        step();
        sync_sec = 1'b0;
        while (cyc < 42) begin
            et = (cyc == 40);
            vectors++; if (tick_sec !== et) begin miscompares++; $display("FAIL sync.tick_sec cyc=%0d got %b want %b", cyc, tick_sec, et); end
            vectors++; if (tick_base !== base_exp(cyc)) begin miscompares++; $display("FAIL sync.tick_base cyc=%0d got %b want %b", cyc, tick_base, base_exp(cyc)); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic es;
        release_reset(2);
        advance_to(5);
        cfg_valid = 1'b1;
        cfg_div   = 8'd7;
        fast_en   = 1'b1;
        step();
        cfg_valid = 1'b0;
        vectors++; if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL mid.pending_ready got %b want 0", cfg_ready); end
        vectors++; if (mode !== M_FAST) begin miscompares++; $display("FAIL mid.pre_mode got %b want 10", mode); end
        rst = 1'b1;
        step();
        step();
        vectors++; if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL mid.rst_ready got %b want 0", cfg_ready); end
        vectors++; if (mode !== M_PAUSE) begin miscompares++; $display("FAIL mid.rst_mode got %b want 01", mode); end
        vectors++; if (tick_base !== 1'b0) begin miscompares++; $display("FAIL mid.rst_tick_base got %b want 0", tick_base); end
        fast_en = 1'b0;
        run_en  = 1'b1;
        rst     = 1'b0;
        step();
        cyc = 0;
        while (cyc < 26) begin
            es = (cyc == 12) || (cyc == 24);
            vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL mid.ready cyc=%0d got %b want 1", cyc, cfg_ready); end
            vectors++; if (tick_sample !== es) begin miscompares++; $display("FAIL mid.tick_sample cyc=%0d got %b want %b", cyc, tick_sample, es); end
            vectors++; if (mode !== M_RUN) begin miscompares++; $display("FAIL mid.mode cyc=%0d got %b want 00", cyc, mode); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_cfg();
        test_pause();
        test_fast();
        test_sync();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/timebase_scheduler.md
Name: timebase_scheduler

Overview:
Central tick scheduler for the digital clock. It runs one shared system-clock prescaler and derives single-cycle enable strobes for three consumers: the display scan (base tick), input debounce sampling (runtime-configurable) and timekeeping seconds (run/pause/fast-set modes). It replaces per-consumer divided clocks with enables in the single clk domain, and sits between the top level and the display, debounce and counter blocks.

Parameters:
CLK_HZ, 100000000, system clock frequency
BASE_HZ, 1000, base tick rate; PRE = CLK_HZ/BASE_HZ, must be an integer >= 2
SEC_DIV, 1000, base ticks per tick_sec in RUN
FAST_DIV, 125, base ticks per tick_sec in FAST (8 Hz)
SAMPLE_DIV_RST, 10, reset value of the sample divider (1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
run_en  in  1  1 = seconds advance, 0 = pause
fast_en  in  1  fast-set mode request; overrides run_en
sync_sec  in  1  zero the seconds phase
cfg_valid  in  1  new sample divider offered
cfg_div  in  8  requested sample divider, in base ticks
cfg_ready  out  1  scheduler can accept a cfg
cfg_err  out  1  1-cycle pulse: cfg_div == 0 rejected
tick_base  out  1  1-cycle strobe at BASE_HZ
tick_sample  out  1  1-cycle strobe every samp_div base ticks
tick_sec  out  1  1-cycle strobe per second (or per fast step)
mode  out  2  00 RUN, 01 PAUSE, 10 FAST

Behaviour:
- All outputs are registered. While rst is high: ticks 0, cfg_err 0, cfg_ready 0, mode 01 (PAUSE), all counters 0, samp_div = SAMPLE_DIV_RST, pending cfg discarded. In the first cycle after rst falls, cfg_ready = 1 and mode reflects the inputs from the next edge.
- Prescaler: free-running 0..PRE-1, runs in every mode. Count the first post-reset cycle as cycle 0; tick_base is high in cycles k*PRE for k >= 1.
- Sample channel: samp_cnt advances on each base tick and wraps at samp_div-1. tick_sample is asserted coincident with the tick_base on which samp_cnt wraps.
- Config handshake: a transfer occurs when cfg_valid && cfg_ready at a clock edge.
  - cfg_div == 0: cfg_err pulses the next cycle, cfg_ready stays 1, no state change.
  - cfg_div != 0: value latched as pending; cfg_ready drops the next cycle.
  - At the next tick_base: samp_div <= pending, samp_cnt <= 0, tick_sample suppressed on that tick, cfg_ready returns to 1 the following cycle. The first new-rate tick_sample comes cfg_div base ticks later.
  - A transfer coincident with tick_base is applied at the following tick_base.
- Mode FSM: next state = FAST if fast_en; else PAUSE if !run_en; else RUN. The register updates every clk edge, and the mode output equals the state.
- Seconds channel: sec_cnt advances on tick_base using the current state register.
  - RUN wraps at SEC_DIV-1; FAST wraps at FAST_DIV-1. tick_sec is coincident with the wrapping tick_base.
  - PAUSE: sec_cnt holds and tick_sec = 0.
  - Any transition into or out of FAST clears sec_cnt. PAUSE<->RUN preserves sec_cnt (phase retained).
- sync_sec: clears sec_cnt at that edge. If it coincides with the wrapping tick_base, sync wins and no tick_sec is issued. The next tick_sec follows a full period.
- Mid-operation reset: overrides everything, including a pending cfg or FAST state.
- Widths: prescaler counter $clog2(PRE); sec_cnt $clog2(max(SEC_DIV,FAST_DIV)); samp_cnt 8 bits. No counter may exceed its wrap value.

Decomposition:
- Package timebase_pkg: mode encodings MODE_RUN/MODE_PAUSE/MODE_FAST and a PRE-derivation function.
- One sub-module, mod_counter: a parameterised-width modulo counter with inputs en, clr and limit, and a registered wrap pulse. It is instantiated for the prescaler, sample and seconds channels. The FSM and cfg handshake live in the top.

Test Plan:
Params for all tests: CLK_HZ=40, BASE_HZ=10 (PRE=4), SEC_DIV=5, FAST_DIV=2, SAMPLE_DIV_RST=3.
1. Reset release, run_en=1 -> tick_base at cycles 4,8,12…; tick_sample at 12,24; tick_sec at 20,40; mode=00.
2. cfg_div=2 offered at cycle 5 -> cfg_ready low cycles 6–8, applied at tick 8, ready high at 9, tick_sample at 16,24; cfg_div=0 -> cfg_err pulse, tick_sample period unchanged.
3. run_en=0 across cycles 10–30 -> mode=01, tick_base continues, no tick_sec; resume -> tick_sec after the remaining 3 base ticks (phase kept).
4. fast_en=1 (any run_en) -> mode=10, sec_cnt cleared, tick_sec every 8 cycles; drop fast_en -> RUN, next tick_sec 20 cycles later.
5. sync_sec pulsed in cycle 20 (coincident wrap) -> no tick_sec at 20, next at 40.
6. rst for 2 cycles while a cfg is pending -> samp_div=3, cfg_ready=1 the cycle after rst falls, tick_sample at 12 cycles post-release.
